// File: rtl/swan_theta_round_ctrl_if.sv
// Start/result and round-key request signals of the SWAN128 round sequencer.
// The abort input exists only when SWAN_THETA_CTRL_ABORT_EN is defined.
interface swan_theta_round_ctrl_if #(
  parameter int BLOCK_SIZE = 128
);
  localparam int SIDE_SIZE = BLOCK_SIZE / 2;

  logic                  start;
  logic [BLOCK_SIZE-1:0] din;
  logic                  busy;
  logic                  done;
  logic [BLOCK_SIZE-1:0] dout;
  logic                  rk_req;
  logic                  rk_ack;
  logic [7:0]            rk_idx;
  logic [SIDE_SIZE-1:0]  rk;
`ifdef SWAN_THETA_CTRL_ABORT_EN
  logic                  abort;

  modport master (
    output start, din, rk_ack, rk, abort,
    input  busy, done, dout, rk_req, rk_idx
  );
  modport slave (
    input  start, din, rk_ack, rk, abort,
    output busy, done, dout, rk_req, rk_idx
  );
`else
  modport master (
    output start, din, rk_ack, rk,
    input  busy, done, dout, rk_req, rk_idx
  );
  modport slave (
    input  start, din, rk_ack, rk,
    output busy, done, dout, rk_req, rk_idx
  );
`endif
endinterface

// File: rtl/swan_theta_round_ctrl.sv
// SWAN128 round sequencer: Feistel rounds with the theta-key transform, one fetched key per round.
// Latency 2*ROUNDS+1 cycles from the start edge to done with zero-wait key acks; each ack wait adds one cycle.
// Waits on rk_ack indefinitely (no timeout); start is ignored unless IDLE. Optional abort: SWAN_THETA_CTRL_ABORT_EN.
module swan_theta_round_ctrl #(
  parameter int BLOCK_SIZE = 128,
  parameter int ROUNDS     = 32,
  parameter int PA         = 1,
  parameter int PB         = 3,
  parameter int PC         = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  swan_theta_round_ctrl_if.slave        bus
);
  localparam int         SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int         COLUMN_SIZE = SIDE_SIZE / 4;
  localparam logic [7:0] LAST_RND    = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KREQ  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [SIDE_SIZE-1:0]  l_q, l_nxt;
  logic [SIDE_SIZE-1:0]  r_q, r_nxt;
  logic [SIDE_SIZE-1:0]  rk_q, rk_nxt;
  logic [7:0]            cnt_q, cnt_nxt;
  logic                  done_q, done_nxt;
  logic [BLOCK_SIZE-1:0] dout_q, dout_nxt;
  logic                  rk_req;
  logic                  abort_hit;

`ifdef SWAN_THETA_CTRL_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Rotation toward the LSB, read out of a doubled copy of the column.
  function automatic logic [COLUMN_SIZE-1:0] rotr(input logic [COLUMN_SIZE-1:0] v, input int n);
    logic [2*COLUMN_SIZE-1:0] dbl;
    int                       s;
    dbl = {v, v};
    s   = n % COLUMN_SIZE;
    return dbl[s +: COLUMN_SIZE];
  endfunction

  // Column 0 is the most significant COLUMN_SIZE bits (MSB-first numbering).
  function automatic logic [SIDE_SIZE-1:0] theta(input logic [SIDE_SIZE-1:0] x,
                                                 input logic [SIDE_SIZE-1:0] k);
    logic [COLUMN_SIZE-1:0] a0, a1, a2, a3;
    a0 = x[4*COLUMN_SIZE-1 -: COLUMN_SIZE];
    a1 = x[3*COLUMN_SIZE-1 -: COLUMN_SIZE];
    a2 = x[2*COLUMN_SIZE-1 -: COLUMN_SIZE];
    a3 = x[COLUMN_SIZE-1:0];
    return {rotr(a0, PC), rotr(a1, PB), rotr(a2, PA), a3} ^ k;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_nxt;
      l_q     <= l_nxt;
      r_q     <= r_nxt;
      rk_q    <= rk_nxt;
      cnt_q   <= cnt_nxt;
      done_q  <= done_nxt;
      dout_q  <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    l_nxt     = l_q;
    r_nxt     = r_q;
    rk_nxt    = rk_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    dout_nxt  = dout_q;
    rk_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          {l_nxt, r_nxt} = bus.din;
          cnt_nxt        = '0;
          state_nxt      = KREQ;
        end
      end
      KREQ: begin
        rk_req = 1'b1;
        if (abort_hit) begin
          state_nxt = IDLE;
        end else if (bus.rk_ack) begin
          rk_nxt    = bus.rk;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        // An abort here discards the round: L/R are not architecturally visible.
        if (abort_hit) begin
          state_nxt = IDLE;
        end else begin
          l_nxt     = r_q;
          r_nxt     = l_q ^ theta(r_q, rk_q);
          cnt_nxt   = cnt_q + 8'd1;
          state_nxt = (cnt_q == LAST_RND) ? DONE : KREQ;
        end
      end
      DONE: begin
        // done and dout update together so done never flags a stale result.
        dout_nxt  = {l_q, r_q};
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.dout   = dout_q;
  assign bus.rk_req = rk_req;
  assign bus.rk_idx = cnt_q;

endmodule
